// File: rtl/johnson_phase_decoder.sv
// johnson_phase_decoder
// Receive-side checker for a 6-stage Johnson (twisted-ring) counter. It
// samples the counter word, decodes it to a phase 0..11, and flags two kinds
// of error: words that are not legal Johnson codes, and legal words that are
// neither a hold nor a +1 step. A lock FSM (UNLOCK/ACQ/LOCKED) reports
// revolutions and keeps a saturating count of errors seen while locked.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   code_in      sampled Johnson word, bit 0 = stage fed by inverted last stage
//   sample_en    qualifies code_in on this edge
//   phase        last decoded legal phase (0..11)
//   phase_valid  a legal phase is held since reset / loss of lock
//   locked       FSM is in LOCKED
//   illegal_err  1-cycle pulse: sample was not a legal Johnson word
//   step_err     1-cycle pulse: legal sample but neither hold nor +1
//   rev_tick     1-cycle pulse: 11 -> 0 advance while LOCKED
//   err_count    saturating count of errors taken while LOCKED
module johnson_phase_decoder #(
  parameter int unsigned STAGES = 6,
  parameter int unsigned LOCK_N = 3,
  parameter int unsigned ERR_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [STAGES-1:0] code_in,
  input  logic              sample_en,
  output logic [3:0]        phase,
  output logic              phase_valid,
  output logic              locked,
  output logic              illegal_err,
  output logic              step_err,
  output logic              rev_tick,
  output logic [ERR_W-1:0]  err_count
);

  localparam int unsigned SEQ_LEN = 2 * STAGES;

  if (STAGES != 6) begin : g_bad_stages
    $error("johnson_phase_decoder supports only STAGES = 6");
  end
  if (LOCK_N < 1 || LOCK_N > 7) begin : g_bad_lock_n
    $error("johnson_phase_decoder: LOCK_N must be 1..7");
  end

  typedef enum logic [1:0] {UNLOCK, ACQ, LOCKED} state_t;

  // Johnson word for phase k: the ring fills with ones from bit 0 upward
  // (k = 0..STAGES), then empties from bit 0 upward.
  function automatic logic [STAGES-1:0] johnson_word(input int unsigned k);
    logic [STAGES-1:0] w;
    w = '0;
    for (int unsigned b = 0; b < STAGES; b++) begin
      w[b] = (k <= STAGES) ? (b < k) : (b >= k - STAGES);
    end
    return w;
  endfunction

  // Stage 1: input capture
  logic [STAGES-1:0] code_q;
  logic              sample_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_q   <= '0;
      sample_q <= 1'b0;
    end else begin
      sample_q <= sample_en;
      if (sample_en) begin
        code_q <= code_in;
      end
    end
  end

  // Stage 2: decode and classify
  logic       dec_legal;
  logic [3:0] dec_phase;
  logic [3:0] phase_inc;
  logic       is_hold;
  logic       is_adv;

  always_comb begin
    dec_legal = 1'b0;
    dec_phase = '0;
    for (int unsigned k = 0; k < SEQ_LEN; k++) begin
      if (code_q == johnson_word(k)) begin
        dec_legal = 1'b1;
        dec_phase = 4'(k);
      end
    end
  end

  assign phase_inc = (phase == 4'(SEQ_LEN - 1)) ? '0 : phase + 4'd1;
  assign is_hold   = (dec_phase == phase);
  assign is_adv    = (dec_phase == phase_inc);

  // Lock FSM
  state_t           state, state_nxt;
  logic [2:0]       good_cnt, cnt_nxt;
  logic [3:0]       phase_nxt;
  logic             pv_nxt;
  logic             ill_nxt, step_nxt, rev_nxt;
  logic [ERR_W-1:0] err_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = good_cnt;
    phase_nxt = phase;
    pv_nxt    = phase_valid;
    err_nxt   = err_count;
    ill_nxt   = 1'b0;
    step_nxt  = 1'b0;
    rev_nxt   = 1'b0;
    if (sample_q) begin
      unique case (state)
        UNLOCK: begin
          if (dec_legal) begin
            phase_nxt = dec_phase;
            pv_nxt    = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ACQ;
          end else begin
            ill_nxt = 1'b1;
          end
        end
        ACQ: begin
          if (!dec_legal) begin
            ill_nxt   = 1'b1;
            pv_nxt    = 1'b0;
            state_nxt = UNLOCK;
          end else if (is_adv) begin
            phase_nxt = dec_phase;
            cnt_nxt   = good_cnt + 3'd1;
            if (good_cnt + 3'd1 == 3'(LOCK_N)) begin
              state_nxt = LOCKED;
            end
          end else if (!is_hold) begin
            // Re-anchor on the new phase and restart the advance count.
            step_nxt  = 1'b1;
            phase_nxt = dec_phase;
            cnt_nxt   = '0;
          end
        end
        LOCKED: begin
          if (dec_legal && (is_adv || is_hold)) begin
            phase_nxt = dec_phase;
            rev_nxt   = is_adv && (dec_phase == '0);
          end else begin
            // Illegal outranks step, so at most one error pulse per sample.
            ill_nxt   = !dec_legal;
            step_nxt  = dec_legal;
            if (err_count != '1) begin
              err_nxt = err_count + 1'b1;
            end
            pv_nxt    = 1'b0;
            state_nxt = UNLOCK;
          end
        end
        default: state_nxt = UNLOCK;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= UNLOCK;
      good_cnt    <= '0;
      phase       <= '0;
      phase_valid <= 1'b0;
      err_count   <= '0;
      illegal_err <= 1'b0;
      step_err    <= 1'b0;
      rev_tick    <= 1'b0;
    end else begin
      state       <= state_nxt;
      good_cnt    <= cnt_nxt;
      phase       <= phase_nxt;
      phase_valid <= pv_nxt;
      err_count   <= err_nxt;
      illegal_err <= ill_nxt;
      step_err    <= step_nxt;
      rev_tick    <= rev_nxt;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Testbench for johnson_phase_decoder: directed scenarios with constant
// expectations, then randomized traffic checked against a behavioural model.
module tb_johnson_phase_decoder;

  localparam int unsigned LOCK_N = 3;
  localparam int unsigned ERR_W  = 4;
  localparam int          ERR_MAX = (1 << ERR_W) - 1;

  logic             clk;
  logic             reset;
  logic [5:0]       code_in;
  logic             sample_en;
  logic [3:0]       phase;
  logic             phase_valid;
  logic             locked;
  logic             illegal_err;
  logic             step_err;
  logic             rev_tick;
  logic [ERR_W-1:0] err_count;

  int tests = 0;
  int fails = 0;

  johnson_phase_decoder #(
    .STAGES(6),
    .LOCK_N(LOCK_N),
    .ERR_W (ERR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .code_in    (code_in),
    .sample_en  (sample_en),
    .phase      (phase),
    .phase_valid(phase_valid),
    .locked     (locked),
    .illegal_err(illegal_err),
    .step_err   (step_err),
    .rev_tick   (rev_tick),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // Legal word for phase k by arithmetic: 2^k-1 while filling, 64-2^(k-6) while draining.
  function automatic logic [5:0] word(input int k);
    int v;
    v = (k <= 6) ? ((1 << k) - 1) : (64 - (1 << (k - 6)));
    return v[5:0];
  endfunction

  function automatic int code_phase(input logic [5:0] c);
    for (int k = 0; k < 12; k++) begin
      if (word(k) == c) return k;
    end
    return -1;
  endfunction

  // Behavioural model: mode 0 = unlocked, 1 = acquiring, 2 = locked.
  int         m_mode, m_phase, m_cnt, m_err;
  bit         m_pv, m_ill, m_step, m_rev;
  bit         p_v;
  logic [5:0] p_code;

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_cnt = 0; m_err = 0;
    m_pv = 0; m_ill = 0; m_step = 0; m_rev = 0;
    p_v = 0; p_code = '0;
  endtask

  task automatic model_step(input logic [5:0] c, input logic e);
    int ph;
    m_ill = 0; m_step = 0; m_rev = 0;
    if (p_v) begin
      ph = code_phase(p_code);
      if (m_mode == 0) begin
        if (ph < 0) m_ill = 1;
        else begin m_phase = ph; m_pv = 1; m_cnt = 0; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (ph < 0) begin m_ill = 1; m_pv = 0; m_mode = 0; end
        else if (ph == (m_phase + 1) % 12) begin
          m_phase = ph; m_cnt++;
          if (m_cnt == LOCK_N) m_mode = 2;
        end else if (ph != m_phase) begin
          m_step = 1; m_phase = ph; m_cnt = 0;
        end
      end else begin
        if (ph >= 0 && (ph == m_phase || ph == (m_phase + 1) % 12)) begin
          if (m_phase == 11 && ph == 0) m_rev = 1;
          m_phase = ph;
        end else begin
          if (ph < 0) m_ill = 1; else m_step = 1;
          if (m_err < ERR_MAX) m_err++;
          m_mode = 0; m_pv = 0;
        end
      end
    end
    p_v = e; p_code = c;
  endtask

  task automatic tick(input logic [5:0] c, input logic e);
    code_in = c; sample_en = e;
    @(posedge clk);
    model_step(c, e);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; code_in = '0; sample_en = 1'b0;
    model_reset();
    #12;
    tests++;
    if ({phase, phase_valid, locked, illegal_err, step_err, rev_tick, err_count} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got=%h exp=0",
               {phase, phase_valid, locked, illegal_err, step_err, rev_tick, err_count});
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_lock();
    for (int i = 0; i <= 4; i++) begin
      tick(word(i), 1'b1);
      if (i == 0) begin
        tests++;
        if (phase_valid !== 1'b0) begin fails++; $display("FAIL lock_latency pv got=%b exp=0", phase_valid); end
      end else begin
        tests++;
        if (phase !== 4'(i - 1) || phase_valid !== 1'b1) begin
          fails++; $display("FAIL lock_phase step=%0d got=%0d/%b exp=%0d/1", i, phase, phase_valid, i - 1);
        end
        tests++;
        if (locked !== (i - 1 >= 3) || {illegal_err, step_err, rev_tick} !== 3'b000) begin
          fails++; $display("FAIL lock_state step=%0d locked=%b pulses=%b exp locked=%b pulses=000",
                            i, locked, {illegal_err, step_err, rev_tick}, (i - 1 >= 3));
        end
      end
    end
  endtask

  task automatic test_wrap();
    for (int k = 5; k <= 12; k++) tick(word(k % 12), 1'b1);
    tests++;
    if (phase !== 4'd11 || locked !== 1'b1 || rev_tick !== 1'b0) begin
      fails++; $display("FAIL wrap_pre got phase=%0d locked=%b rev=%b exp 11/1/0", phase, locked, rev_tick);
    end
    tick(word(1), 1'b1);
    tests++;
    if (rev_tick !== 1'b1 || phase !== 4'd0 || locked !== 1'b1) begin
      fails++; $display("FAIL wrap_rev got rev=%b phase=%0d locked=%b exp 1/0/1", rev_tick, phase, locked);
    end
    tick(word(1), 1'b1);
    tests++;
    if (rev_tick !== 1'b0 || phase !== 4'd1) begin
      fails++; $display("FAIL wrap_after got rev=%b phase=%0d exp 0/1", rev_tick, phase);
    end
    tick(word(2), 1'b1);
    tests++;
    if (phase !== 4'd1 || locked !== 1'b1 || {illegal_err, step_err, rev_tick} !== 3'b000) begin
      fails++; $display("FAIL hold got phase=%0d locked=%b pulses=%b exp 1/1/000",
                        phase, locked, {illegal_err, step_err, rev_tick});
    end
  endtask

  task automatic test_illegal();
    tick(6'b010101, 1'b1);
    tests++;
    if (phase !== 4'd2 || locked !== 1'b1) begin
      fails++; $display("FAIL illegal_pre got phase=%0d locked=%b exp 2/1", phase, locked);
    end
    tick('0, 1'b0);
    tests++;
    if (illegal_err !== 1'b1 || step_err !== 1'b0 || err_count !== 4'd1 || locked !== 1'b0
        || phase_valid !== 1'b0 || phase !== 4'd2) begin
      fails++; $display("FAIL illegal_hit ill=%b step=%b err=%0d locked=%b pv=%b phase=%0d exp 1/0/1/0/0/2",
                        illegal_err, step_err, err_count, locked, phase_valid, phase);
    end
    tick('0, 1'b0);
    tests++;
    if (illegal_err !== 1'b0 || err_count !== 4'd1 || phase !== 4'd2) begin
      fails++; $display("FAIL illegal_pulse_width ill=%b err=%0d phase=%0d exp 0/1/2", illegal_err, err_count, phase);
    end
  endtask

  task automatic test_step();
    for (int i = 0; i <= 4; i++) tick(word(i), 1'b1);
    tick(word(6), 1'b1);
    tests++;
    if (phase !== 4'd4 || locked !== 1'b1) begin
      fails++; $display("FAIL step_pre got phase=%0d locked=%b exp 4/1", phase, locked);
    end
    tick('0, 1'b0);
    tests++;
    if (step_err !== 1'b1 || illegal_err !== 1'b0 || err_count !== 4'd2 || locked !== 1'b0
        || phase_valid !== 1'b0 || phase !== 4'd4) begin
      fails++; $display("FAIL step_hit step=%b ill=%b err=%0d locked=%b pv=%b phase=%0d exp 1/0/2/0/0/4",
                        step_err, illegal_err, err_count, locked, phase_valid, phase);
    end
    tick(word(0), 1'b1);
    tests++;
    if (step_err !== 1'b0) begin fails++; $display("FAIL step_pulse_width got=%b exp=0", step_err); end
    tick('0, 1'b0);
    tests++;
    if (phase !== 4'd0 || phase_valid !== 1'b1 || locked !== 1'b0 || illegal_err !== 1'b0 || step_err !== 1'b0) begin
      fails++; $display("FAIL step_restart phase=%0d pv=%b locked=%b exp 0/1/0", phase, phase_valid, locked);
    end
    tick('0, 1'b0);
  endtask

  task automatic test_saturate();
    int exp_err;
    bit ok;
    exp_err = 2;
    ok = 1;
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i <= 3; i++) tick(word(i), 1'b1);
      tick(word(6), 1'b1);
      tick('0, 1'b0);
      exp_err = (exp_err < ERR_MAX) ? exp_err + 1 : ERR_MAX;
      tests++;
      if (step_err !== 1'b1 || int'(err_count) != exp_err || locked !== 1'b0) begin
        fails++; $display("FAIL saturate it=%0d step=%b err=%0d locked=%b exp 1/%0d/0",
                          it, step_err, err_count, locked, exp_err);
      end
      tick('0, 1'b0);
    end
    tests++;
    if (err_count !== 4'd15) begin fails++; $display("FAIL saturate_final got=%0d exp=15", err_count); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); reset = 1'b1; model_reset();
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i <= 4; i++) tick(word(i), 1'b1);
    for (int k = 5; k <= 12; k++) tick(word(k % 12), 1'b1);
    tick(word(1), 1'b1);
    tests++;
    if (rev_tick !== 1'b1 || locked !== 1'b1) begin
      fails++; $display("FAIL rstmid_pre rev=%b locked=%b exp 1/1", rev_tick, locked);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({phase, phase_valid, locked, illegal_err, step_err, rev_tick, err_count} !== '0) begin
      fails++; $display("FAIL rstmid_async got=%h exp=0",
                        {phase, phase_valid, locked, illegal_err, step_err, rev_tick, err_count});
    end
    model_reset();
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i <= 4; i++) tick(word(i), 1'b1);
    tests++;
    if (locked !== 1'b1 || phase !== 4'd3 || err_count !== '0) begin
      fails++; $display("FAIL rstmid_relock locked=%b phase=%0d err=%0d exp 1/3/0", locked, phase, err_count);
    end
  endtask

  task automatic test_random();
    int g, r;
    logic [5:0] c;
    logic e;
    logic [13:0] got, exp;
    g = 4;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      e = 1'b1;
      if (r < 55) begin g = (g + 1) % 12; c = word(g); end
      else if (r < 70) c = word(g);
      else if (r < 80) begin g = (g + int'($urandom_range(2, 11))) % 12; c = word(g); end
      else if (r < 90) begin
        c = 6'($urandom);
        while (code_phase(c) >= 0) c = 6'($urandom);
      end else begin c = 6'($urandom); e = 1'b0; end
      tick(c, e);
      got = {phase, phase_valid, locked, illegal_err, step_err, rev_tick, err_count};
      exp = {4'(m_phase), m_pv, (m_mode == 2), m_ill, m_step, m_rev, 4'(m_err)};
      tests++;
      if (got !== exp) begin
        fails++; $display("FAIL random cyc=%0d got=%h exp=%h", n, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_illegal();
    test_step();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
